branch_predictor: RTL and testbench

- Fetch-side counterpart to the execute-stage branch resolution logic.
- At fetch it predicts whether the instruction at fetch_pc is a taken branch, and where it goes.
- Execute reports the resolved outcome (taken flag, target, what was predicted) on the update port; the block trains itself and flags mispredicts.
- Structure: direct-mapped branch target buffer (BTB) with a 2-bit saturating counter per entry, plus 32-bit statistics counters.

---
 rtl/branch_predictor_pkg.sv | 12 +
 rtl/branch_predictor_if.sv | 50 +++++
 rtl/branch_predictor_sat_counter2.sv | 22 ++
 rtl/branch_predictor.sv | 109 ++++++++++
 tb/tb_branch_predictor.sv | 144 ++++++++++++++
 5 files changed

// File: rtl/branch_predictor_pkg.sv
// Shared constants for the fetch-side branch predictor.
// Counter encodings and the sequential PC step.
package branch_predictor_pkg;

  localparam logic [1:0] CTR_SNT = 2'b00;
  localparam logic [1:0] CTR_WNT = 2'b01;
  localparam logic [1:0] CTR_WT  = 2'b10;
  localparam logic [1:0] CTR_ST  = 2'b11;

  localparam logic [31:0] PC_INC = 32'd4;

endpackage

// File: rtl/branch_predictor_if.sv
// Fetch lookup, execute update and statistics bundle.
// The master side is the pipeline; the slave side is the predictor.
interface branch_predictor_if;

  logic [31:0] fetch_pc;
  logic        pred_taken;
  logic [31:0] pred_target;

  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        upd_pred_taken;
  logic [31:0] upd_pred_target;
  logic        mispredict;

  logic [31:0] stat_branches;
  logic [31:0] stat_mispredicts;

  modport master (
    output fetch_pc,
    output upd_valid,
    output upd_pc,
    output upd_taken,
    output upd_target,
    output upd_pred_taken,
    output upd_pred_target,
    input  pred_taken,
    input  pred_target,
    input  mispredict,
    input  stat_branches,
    input  stat_mispredicts
  );

  modport slave (
    input  fetch_pc,
    input  upd_valid,
    input  upd_pc,
    input  upd_taken,
    input  upd_target,
    input  upd_pred_taken,
    input  upd_pred_target,
    output pred_taken,
    output pred_target,
    output mispredict,
    output stat_branches,
    output stat_mispredicts
  );

endinterface

// File: rtl/branch_predictor_sat_counter2.sv
// Next state of a 2-bit saturating taken/not-taken counter.
// Saturates at strong-taken and strong-not-taken.
module sat_counter2
  import branch_predictor_pkg::*;
(
  input  logic [1:0] ctr_i,
  input  logic       taken_i,
  output logic [1:0] ctr_o
);

  always_comb begin
    ctr_o = ctr_i;
    unique case (1'b1)
      (taken_i && ctr_i != CTR_ST):
        ctr_o = ctr_i + 2'd1;
      (!taken_i && ctr_i != CTR_SNT):
        ctr_o = ctr_i - 2'd1;
      default: ;
    endcase
  end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit counters and branch statistics.
// Lookups read pre-update state; updates land on the clock edge.
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int INDEX_BITS = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  branch_predictor_if.slave  bp
);

  localparam int ENTRIES  = 1 << INDEX_BITS;
  localparam int TAG_BITS = 32 - INDEX_BITS - 2;

  logic [ENTRIES-1:0]  valid_q, valid_d;
  logic [TAG_BITS-1:0] tag_q    [ENTRIES];
  logic [TAG_BITS-1:0] tag_d    [ENTRIES];
  logic [31:0]         target_q [ENTRIES];
  logic [31:0]         target_d [ENTRIES];
  logic [1:0]          ctr_q    [ENTRIES];
  logic [1:0]          ctr_d    [ENTRIES];
  logic [31:0]         br_q, br_d;
  logic [31:0]         mp_q, mp_d;

  logic [INDEX_BITS-1:0] f_idx, u_idx;
  logic [TAG_BITS-1:0]   f_tag, u_tag;
  logic                  f_hit, u_hit;
  logic [1:0]            ctr_nxt;
  logic                  mp;

  assign f_idx = bp.fetch_pc[INDEX_BITS+1:2];
  assign f_tag = bp.fetch_pc[31:INDEX_BITS+2];
  assign u_idx = bp.upd_pc[INDEX_BITS+1:2];
  assign u_tag = bp.upd_pc[31:INDEX_BITS+2];

  assign f_hit = valid_q[f_idx]
              && (tag_q[f_idx] == f_tag);
  assign u_hit = valid_q[u_idx]
              && (tag_q[u_idx] == u_tag);

  assign bp.pred_taken  = f_hit && ctr_q[f_idx][1];
  assign bp.pred_target = bp.pred_taken
                        ? target_q[f_idx]
                        : bp.fetch_pc + PC_INC;

  assign mp = bp.upd_valid
           && ((bp.upd_taken != bp.upd_pred_taken)
            || (bp.upd_taken
             && bp.upd_target != bp.upd_pred_target));
  assign bp.mispredict = mp;

  assign bp.stat_branches    = br_q;
  assign bp.stat_mispredicts = mp_q;

  sat_counter2 u_ctr (
    .ctr_i   (ctr_q[u_idx]),
    .taken_i (bp.upd_taken),
    .ctr_o   (ctr_nxt)
  );

  always_comb begin
    valid_d  = valid_q;
    tag_d    = tag_q;
    target_d = target_q;
    ctr_d    = ctr_q;
    br_d     = br_q;
    mp_d     = mp_q;
    if (bp.upd_valid) begin
      br_d = br_q + 32'd1;
      if (mp) mp_d = mp_q + 32'd1;
      unique case (1'b1)
        u_hit: begin
          ctr_d[u_idx] = ctr_nxt;
          if (bp.upd_taken)
            target_d[u_idx] = bp.upd_target;
        end
        (!u_hit && bp.upd_taken): begin
          valid_d[u_idx]  = 1'b1;
          tag_d[u_idx]    = u_tag;
          target_d[u_idx] = bp.upd_target;
          ctr_d[u_idx]    = CTR_WT;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= '0;
      ctr_q   <= '{default: CTR_WNT};
      br_q    <= '0;
      mp_q    <= '0;
    end else begin
      valid_q <= valid_d;
      ctr_q   <= ctr_d;
      br_q    <= br_d;
      mp_q    <= mp_d;
    end
  end

  // Tags/targets are qualified by valid, so they skip reset.
  always_ff @(posedge clk) begin
    tag_q    <= tag_d;
    target_q <= target_d;
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed scoreboard bench for branch_predictor.
// Stimulus queues expectations; a negedge monitor checks them.
module tb_branch_predictor;

  logic clk;
  logic rst_n;

  branch_predictor_if bp_i ();

  branch_predictor dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bp    (bp_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       nm;
    logic        pt;
    logic [31:0] tgt;
    logic        mp;
    logic [31:0] sb;
    logic [31:0] sm;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk({e.nm, ".pt"}, {31'd0, bp_i.pred_taken},
          {31'd0, e.pt});
      chk({e.nm, ".tgt"}, bp_i.pred_target, e.tgt);
      chk({e.nm, ".mp"}, {31'd0, bp_i.mispredict},
          {31'd0, e.mp});
      chk({e.nm, ".sb"}, bp_i.stat_branches, e.sb);
      chk({e.nm, ".sm"}, bp_i.stat_mispredicts, e.sm);
    end
  end

  task automatic cyc(
    input string       nm,
    input logic        rst,
    input logic [31:0] fpc,
    input logic        uv,
    input logic [31:0] upc,
    input logic        ut,
    input logic [31:0] utgt,
    input logic        upt,
    input logic [31:0] uptgt,
    input logic        ept,
    input logic [31:0] etgt,
    input logic        emp,
    input logic [31:0] esb,
    input logic [31:0] esm
  );
    exp_t e;
    @(posedge clk);
    #1;
    rst_n                   = rst;
    bp_i.fetch_pc           = fpc;
    bp_i.upd_valid          = uv;
    bp_i.upd_pc             = upc;
    bp_i.upd_taken          = ut;
    bp_i.upd_target         = utgt;
    bp_i.upd_pred_taken     = upt;
    bp_i.upd_pred_target    = uptgt;
    e.nm  = nm;
    e.pt  = ept;
    e.tgt = etgt;
    e.mp  = emp;
    e.sb  = esb;
    e.sm  = esm;
    q.push_back(e);
  endtask

  localparam logic [31:0] Z = 32'd0;

  initial begin
    int budget;
    rst_n                = 1'b0;
    bp_i.fetch_pc        = 32'h100;
    bp_i.upd_valid       = 1'b0;
    bp_i.upd_pc          = Z;
    bp_i.upd_taken       = 1'b0;
    bp_i.upd_target      = Z;
    bp_i.upd_pred_taken  = 1'b0;
    bp_i.upd_pred_target = Z;
    repeat (2) @(posedge clk);

    //   name      rst fpc          uv upc     ut utgt    upt uptgt    pt tgt          mp sb sm
    cyc("rst0",   1, 32'h100,      0, Z,       0, Z,      0, Z,       0, 32'h104,     0, 0, 0);
    cyc("upd1",   1, 32'h100,      1, 32'h100, 1, 32'h80, 0, 32'h104, 0, 32'h104,     1, 0, 0);
    cyc("trn1",   1, 32'h100,      1, 32'h100, 1, 32'h80, 1, 32'h80,  1, 32'h80,      0, 1, 1);
    cyc("trn2",   1, 32'h100,      1, 32'h100, 1, 32'h80, 1, 32'h80,  1, 32'h80,      0, 2, 1);
    cyc("nt1",    1, 32'h100,      1, 32'h100, 0, Z,      1, 32'h80,  1, 32'h80,      1, 3, 1);
    cyc("nt2",    1, 32'h100,      1, 32'h100, 0, Z,      1, 32'h80,  1, 32'h80,      1, 4, 2);
    cyc("wnt",    1, 32'h100,      0, Z,       0, Z,      0, Z,       0, 32'h104,     0, 5, 3);
    cyc("retake", 1, 32'h100,      1, 32'h100, 1, 32'h80, 0, 32'h104, 0, 32'h104,     1, 5, 3);
    cyc("tchg",   1, 32'h100,      1, 32'h100, 1, 32'h90, 1, 32'h80,  1, 32'h80,      1, 6, 4);
    cyc("tnew",   1, 32'h100,      0, Z,       0, Z,      0, Z,       1, 32'h90,      0, 7, 5);
    cyc("alias",  1, 32'h140,      1, 32'h140, 1, 32'h300,0, 32'h144, 0, 32'h144,     1, 7, 5);
    cyc("a140",   1, 32'h140,      0, Z,       0, Z,      0, Z,       1, 32'h300,     0, 8, 6);
    cyc("a100",   1, 32'h100,      0, Z,       0, Z,      0, Z,       0, 32'h104,     0, 8, 6);
    cyc("nt200",  1, 32'h200,      1, 32'h200, 0, Z,      0, 32'h204, 0, 32'h204,     0, 8, 6);
    cyc("n200",   1, 32'h200,      0, Z,       0, Z,      0, Z,       0, 32'h204,     0, 9, 6);
    cyc("k140",   1, 32'h140,      0, Z,       0, Z,      0, Z,       1, 32'h300,     0, 9, 6);
    cyc("wrap",   1, 32'hFFFFFFFC, 0, 32'h100, 1, 32'h80, 0, 32'h104, 0, 32'h0,       0, 9, 6);
    cyc("rstupd", 0, 32'h140,      1, 32'h100, 1, 32'h80, 0, 32'h104, 1, 32'h300,     1, 9, 6);
    cyc("post",   1, 32'h100,      0, Z,       0, Z,      0, Z,       0, 32'h104,     0, 0, 0);
    cyc("p140",   1, 32'h140,      0, Z,       0, Z,      0, Z,       0, 32'h144,     0, 0, 0);

    budget = 0;
    while (q.size() > 0 && budget < 10) begin
      @(posedge clk);
      budget++;
    end
    @(posedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain left=%0d want=0", q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
